// File: rtl/vga_sync_gen_if.sv
// Pixel-coordinate interface between the VGA raster generator (master)
// and the renderers that consume pixel coordinates and sync timing (slave).
interface vga_sync_gen_if;
    logic        pix_en;
    logic [15:0] h_counter;
    logic [15:0] v_counter;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic        frame_start;

    // Timing generator drives everything.
    modport master (
        output pix_en,
        output h_counter,
        output v_counter,
        output hsync,
        output vsync,
        output video_on,
        output frame_start
    );

    // Renderers and the connector only observe.
    modport slave (
        input pix_en,
        input h_counter,
        input v_counter,
        input hsync,
        input vsync,
        input video_on,
        input frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// Free-running VGA raster timing generator.
// The board clock is divided down to a one-clk pixel strobe (pix_en); the
// column/line counters and the registered sync outputs advance only on that
// strobe. Default timing is 640x480@60 (800x525 total) at CLK_DIV=2.
//
// Optional build macro VGA_SYNC_PIPE_EN: hsync, vsync and video_on are
// delayed by one pixel relative to h_counter/v_counter, so they line up with
// renderers that register their colour output on pix_en. pix_en, the
// counters and frame_start are identical in both builds.
//
// Interface handshake: there is no back-pressure. pix_en acts as the valid
// strobe; a consumer samples h_counter/v_counter/frame_start on any clk edge
// where pix_en=1, and the coordinates are stable for the CLK_DIV clks between
// strobes.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter int SYNC_POL = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    vga_sync_gen_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Decode points, all held at the full 16-bit counter width.
    localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_VIS    = 16'(H_ACTIVE);
    localparam logic [15:0] V_VIS    = 16'(V_ACTIVE);
    localparam logic [15:0] HS_START = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] VS_START = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);

    // CLK_DIV is at most 16, so the divider fits in 4 bits.
    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    // Level driven on hsync/vsync while the pulse is asserted.
    localparam logic SYNC_ON = (SYNC_POL != 0);

    logic [3:0]  div_q;
    logic [3:0]  div_d;
    logic        pix_en;
    logic [15:0] h_q;
    logic [15:0] h_d;
    logic [15:0] v_q;
    logic [15:0] v_d;
    logic        hsync_d;
    logic        vsync_d;
    logic        hsync_q;
    logic        vsync_q;
    logic        video_now;
    logic        frame_start;

    // Divider next value: count 0..CLK_DIV-1 and wrap.
    always_comb begin
        div_d = div_q + 4'd1;
        if (div_q == DIV_LAST) begin
            div_d = 4'd0;
        end
    end

    // Divider register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= 4'd0;
        end else begin
            div_d_apply: div_q <= div_d;
        end
    end

    // With CLK_DIV=1 the divider compare is constantly true, so the strobe is
    // also gated by rst_n to keep it low while the generator is held in reset.
    assign pix_en = rst_n & (div_q == DIV_LAST);

    // Raster next-state: h wraps at the end of the line and carries into v in
    // the same edge; v wraps at the end of the frame so both hit 0 together.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (pix_en) begin
            if (h_q == H_LAST) begin
                h_d = 16'd0;
                if (v_q == V_LAST) begin
                    v_d = 16'd0;
                end else begin
                    v_d = v_q + 16'd1;
                end
            end else begin
                h_d = h_q + 16'd1;
            end
        end
    end

    // Sync decode on the next-state counters so the registered syncs change
    // on the same edge as the counters they describe.
    always_comb begin
        hsync_d = ~SYNC_ON;
        vsync_d = ~SYNC_ON;
        if ((h_d >= HS_START) && (h_d < HS_END)) begin
            hsync_d = SYNC_ON;
        end
        if ((v_d >= VS_START) && (v_d < VS_END)) begin
            vsync_d = SYNC_ON;
        end
    end

    // Counter and sync registers; reset parks the raster at (0,0) with both
    // syncs idle so no partial pulse survives a mid-frame reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q     <= 16'd0;
            v_q     <= 16'd0;
            hsync_q <= ~SYNC_ON;
            vsync_q <= ~SYNC_ON;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    // Visible-area and frame-origin decode of the registered counters.
    // video_now is 1 during reset because (0,0) is a visible pixel.
    always_comb begin
        video_now   = (h_q < H_VIS) && (v_q < V_VIS);
        frame_start = pix_en && (h_q == 16'd0) && (v_q == 16'd0);
    end

    assign vga.pix_en      = pix_en;
    assign vga.h_counter   = h_q;
    assign vga.v_counter   = v_q;
    assign vga.frame_start = frame_start;

`ifdef VGA_SYNC_PIPE_EN
    logic hsync_p;
    logic vsync_p;
    logic video_p;

    // One-pixel delay stage: captures the current pixel's sync/visible state
    // on the strobe that moves the counters on to the next pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_p <= ~SYNC_ON;
            vsync_p <= ~SYNC_ON;
            video_p <= 1'b0;
        end else if (pix_en) begin
            hsync_p <= hsync_q;
            vsync_p <= vsync_q;
            video_p <= video_now;
        end
    end

    assign vga.hsync    = hsync_p;
    assign vga.vsync    = vsync_p;
    assign vga.video_on = video_p;
`else
    assign vga.hsync    = hsync_q;
    assign vga.vsync    = vsync_q;
    assign vga.video_on = video_now;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Testbench for vga_sync_gen. Three generators share one clock:
//   dut_a: default 640x480 timing, CLK_DIV=2, active-low syncs
//   dut_b: small 15x8 raster, CLK_DIV=2, active-low syncs (full frames, mid-frame reset)
//   dut_c: same small raster, CLK_DIV=1, active-high syncs
// A driver pushes the expected per-pixel raster tuple into a queue per DUT;
// a monitor per DUT samples on the falling edge and pops on each pixel strobe.
`timescale 1ns/1ps
module tb_vga_sync_gen;

`ifdef VGA_SYNC_PIPE_EN
    localparam bit PIPED = 1'b1;
`else
    localparam bit PIPED = 1'b0;
`endif

    // Small raster used by dut_b and dut_c: H 8+2+3+2=15, V 4+1+2+1=8.
    localparam int SHA = 8;
    localparam int SHF = 2;
    localparam int SHS = 3;
    localparam int SHB = 2;
    localparam int SVA = 4;
    localparam int SVF = 1;
    localparam int SVS = 2;
    localparam int SVB = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    logic rst_c;

    always #5 clk = ~clk;

    vga_sync_gen_if if_a ();
    vga_sync_gen_if if_b ();
    vga_sync_gen_if if_c ();

    vga_sync_gen dut_a (
        .clk   (clk),
        .rst_n (rst_a),
        .vga   (if_a)
    );

    vga_sync_gen #(
        .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
        .CLK_DIV(2), .SYNC_POL(0)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_b),
        .vga   (if_b)
    );

    vga_sync_gen #(
        .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
        .CLK_DIV(1), .SYNC_POL(1)
    ) dut_c (
        .clk   (clk),
        .rst_n (rst_c),
        .vga   (if_c)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    // Tuple layout: {h[15:0], v[15:0], hsync, vsync, video_on, frame_start}
    logic [35:0] exp_qa[$];
    logic [35:0] exp_qb[$];
    logic [35:0] exp_qc[$];

    task automatic compare(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outputs for the k-th pixel after reset release.
    function automatic logic [35:0] model_px(input int k, input int ha, input int hf,
                                             input int hs, input int hb, input int va,
                                             input int vf, input int vs, input int vb,
                                             input bit pol);
        int ht, vt, h, v, sk, sh, sv;
        logic hsa, vsa, vo;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        h  = k % ht;
        v  = (k / ht) % vt;
        sk = PIPED ? k - 1 : k;
        if (sk < 0) begin
            hsa = 1'b0;
            vsa = 1'b0;
            vo  = 1'b0;
        end else begin
            sh  = sk % ht;
            sv  = (sk / ht) % vt;
            hsa = (sh >= ha + hf) && (sh < ha + hf + hs);
            vsa = (sv >= va + vf) && (sv < va + vf + vs);
            vo  = (sh < ha) && (sv < va);
        end
        return {h[15:0], v[15:0], hsa ? pol : ~pol, vsa ? pol : ~pol, vo, (h == 0) && (v == 0)};
    endfunction

    function automatic logic [35:0] reset_tuple(input bit pol);
        return {16'd0, 16'd0, ~pol, ~pol, ~PIPED, 1'b0};
    endfunction

    // ---------------- monitor A: default timing ----------------
    int cyc_a;
    int a_hs_cnt;
    int a_hs_first;
    int a_hs_last;
    bit a_line_done;

    always @(negedge clk) begin : mon_a
        logic [35:0] e;
        logic pe;
        if (!rst_a) begin
            cyc_a = 0; a_hs_cnt = 0; a_hs_first = -1; a_hs_last = -1; a_line_done = 1'b0;
        end else if (exp_qa.size() != 0) begin
            pe = (cyc_a % 2) == 1;
            e  = exp_qa[0];
            if (!pe) e[0] = 1'b0;
            compare("a_pix_en", 36'(if_a.pix_en), 36'(pe));
            compare("a_raster", {if_a.h_counter, if_a.v_counter, if_a.hsync, if_a.vsync,
                                 if_a.video_on, if_a.frame_start}, e);
            if (pe) begin
                if (if_a.v_counter == 16'd0 && if_a.hsync == 1'b0) begin
                    a_hs_cnt++;
                    if (a_hs_first < 0) a_hs_first = int'(if_a.h_counter);
                    a_hs_last = int'(if_a.h_counter);
                end
                if (!a_line_done && if_a.v_counter == 16'd1) begin
                    a_line_done = 1'b1;
                    compare("a_hsync_width", 36'(a_hs_cnt), 36'd96);
                    compare("a_hsync_first", 36'(a_hs_first), PIPED ? 36'd657 : 36'd656);
                    compare("a_hsync_last", 36'(a_hs_last), PIPED ? 36'd752 : 36'd751);
                end
                void'(exp_qa.pop_front());
            end
            cyc_a++;
        end
    end

    // ---------------- monitor B: small raster, CLK_DIV=2 ----------------
    int cyc_b;
    bit b_have_frame;
    int b_pix_cnt;
    int b_vid_cnt;
    int b_frames;

    always @(negedge clk) begin : mon_b
        logic [35:0] e;
        logic pe;
        if (!rst_b) begin
            cyc_b = 0; b_have_frame = 1'b0; b_pix_cnt = 0; b_vid_cnt = 0; b_frames = 0;
        end else if (exp_qb.size() != 0) begin
            pe = (cyc_b % 2) == 1;
            e  = exp_qb[0];
            if (!pe) e[0] = 1'b0;
            compare("b_pix_en", 36'(if_b.pix_en), 36'(pe));
            compare("b_raster", {if_b.h_counter, if_b.v_counter, if_b.hsync, if_b.vsync,
                                 if_b.video_on, if_b.frame_start}, e);
            if (pe) begin
                if (if_b.frame_start) begin
                    if (b_have_frame) begin
                        compare("b_frame_pixels", 36'(b_pix_cnt), 36'd120);
                        compare("b_frame_visible", 36'(b_vid_cnt), 36'd32);
                        b_frames++;
                    end
                    b_have_frame = 1'b1;
                    b_pix_cnt = 0;
                    b_vid_cnt = 0;
                end
                b_pix_cnt++;
                if (if_b.video_on) b_vid_cnt++;
                void'(exp_qb.pop_front());
            end
            cyc_b++;
        end
    end

    // ---------------- monitor C: small raster, CLK_DIV=1, active-high ----------------
    bit c_prev_hs;
    bit c_prev_vo;
    int c_rise;
    int c_fall;
    int c_drop;
    bit c_line_done;

    always @(negedge clk) begin : mon_c
        logic [35:0] e;
        if (!rst_c) begin
            c_prev_hs = 1'b0; c_prev_vo = 1'b0; c_rise = -1; c_fall = -1; c_drop = -1;
            c_line_done = 1'b0;
        end else if (exp_qc.size() != 0) begin
            e = exp_qc[0];
            compare("c_pix_en", 36'(if_c.pix_en), 36'd1);
            compare("c_raster", {if_c.h_counter, if_c.v_counter, if_c.hsync, if_c.vsync,
                                 if_c.video_on, if_c.frame_start}, e);
            if (if_c.v_counter == 16'd0) begin
                if (if_c.hsync && !c_prev_hs && c_rise < 0) c_rise = int'(if_c.h_counter);
                if (!if_c.hsync && c_prev_hs && c_fall < 0) c_fall = int'(if_c.h_counter);
                if (!if_c.video_on && c_prev_vo && c_drop < 0) c_drop = int'(if_c.h_counter);
                c_prev_hs = if_c.hsync;
                c_prev_vo = if_c.video_on;
            end else if (!c_line_done) begin
                c_line_done = 1'b1;
                compare("c_hsync_rise_h", 36'(c_rise), PIPED ? 36'd11 : 36'd10);
                compare("c_hsync_fall_h", 36'(c_fall), PIPED ? 36'd14 : 36'd13);
                compare("c_video_drop_h", 36'(c_drop), PIPED ? 36'd9 : 36'd8);
            end
            void'(exp_qc.pop_front());
        end
    end

    // ---------------- driver ----------------
    initial begin : driver
        bit found;
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state of all three generators.
        compare("a_reset_raster", {if_a.h_counter, if_a.v_counter, if_a.hsync, if_a.vsync,
                                   if_a.video_on, if_a.frame_start}, reset_tuple(1'b0));
        compare("a_reset_pix_en", 36'(if_a.pix_en), 36'd0);
        compare("b_reset_raster", {if_b.h_counter, if_b.v_counter, if_b.hsync, if_b.vsync,
                                   if_b.video_on, if_b.frame_start}, reset_tuple(1'b0));
        compare("b_reset_pix_en", 36'(if_b.pix_en), 36'd0);
        compare("c_reset_raster", {if_c.h_counter, if_c.v_counter, if_c.hsync, if_c.vsync,
                                   if_c.video_on, if_c.frame_start}, reset_tuple(1'b1));
        compare("c_reset_pix_en", 36'(if_c.pix_en), 36'd0);

        // Release just after a rising edge and queue the expected raster.
        @(posedge clk);
        #1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;
        for (int k = 0; k < 1700; k++) exp_qa.push_back(model_px(k, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
        for (int k = 0; k < 100; k++)  exp_qb.push_back(model_px(k, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b0));
        for (int k = 0; k < 360; k++)  exp_qc.push_back(model_px(k, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b1));

        // Mid-frame reset of dut_b at (11,5), inside both sync pulses.
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (if_b.h_counter == 16'd11 && if_b.v_counter == 16'd5) begin
                found = 1'b1;
                break;
            end
        end
        compare("b_reach_11_5", 36'(found), 36'd1);
        #2;
        rst_b = 1'b0;
        exp_qb.delete();
        #1;
        compare("b_midreset_raster", {if_b.h_counter, if_b.v_counter, if_b.hsync, if_b.vsync,
                                      if_b.video_on, if_b.frame_start}, reset_tuple(1'b0));
        compare("b_midreset_pix_en", 36'(if_b.pix_en), 36'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_b = 1'b1;
        for (int k = 0; k < 241; k++) exp_qb.push_back(model_px(k, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b0));

        // Let every queue drain, with a bounded wait.
        for (int i = 0; i < 6000; i++) begin
            if (exp_qa.size() == 0 && exp_qb.size() == 0 && exp_qc.size() == 0) break;
            @(negedge clk);
        end
        compare("drain_a", 36'(exp_qa.size()), 36'd0);
        compare("drain_b", 36'(exp_qb.size()), 36'd0);
        compare("drain_c", 36'(exp_qc.size()), 36'd0);
        compare("a_line_checked", 36'(a_line_done), 36'd1);
        compare("b_frames_checked", 36'(b_frames), 36'd2);
        compare("c_line_checked", 36'(c_line_done), 36'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
